// File: rtl/qpsk_sym_sched_pkg.sv
// qpsk_sym_sched_pkg
//   Shared types and constants for the QPSK 32-bit-to-2-bit symbol scheduler.
//   Contents: FSM state enum, word/symbol geometry, and the symbol-select
//   helper used to pick symbol k out of a packed 32-bit word.
//   No ports (package).
package qpsk_sym_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned SYM_W        = 2;
    localparam int unsigned SYM_PER_WORD = WORD_W / SYM_W;

    // msb_first=1: symbol k = word[31-2k -: 2]; msb_first=0: word[2k+1:2k].
    function automatic logic [SYM_W-1:0] sym_sel(input logic [WORD_W-1:0] word,
                                                 input logic [3:0]        idx,
                                                 input logic              msb_first);
        logic [3:0] pos;
        pos = msb_first ? (4'(SYM_PER_WORD - 1) - idx) : idx;
        return word[{pos, 1'b0} +: SYM_W];
    endfunction

endpackage

// File: rtl/qpsk_sym_sched_if.sv
// qpsk_sym_sched_if
//   AXI-Stream style handshake bundle used on both sides of the scheduler.
//   Signals: tdata[DATA_W-1:0], tlast, tvalid, tready.
//   Modports: master (drives tdata/tlast/tvalid, receives tready),
//             slave  (receives tdata/tlast/tvalid, drives tready).
interface qpsk_sym_sched_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/qpsk_sym_sched_pacer.sv
// qpsk_sym_pacer
//   Rate-divider down-counter that paces output beats.
//   Ports:
//     clk, rst       block clock, synchronous active-high reset
//     clr_i          force the count to zero (start of a fresh word)
//     load_i         load load_val_i (on an output handshake)
//     hold_i         freeze the count (beat stalled by downstream)
//     load_val_i     reload value, already reduced to max(div,1)-1
//     zero_o         count is zero: a beat may be presented
module qpsk_sym_pacer #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             hold_i,
    input  logic [DIV_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/qpsk_sym_sched.sv
// qpsk_sym_sched
//   Scheduler/sequencer for the conv32Bto2B QPSK path. Accepts 32-bit words,
//   emits 16 two-bit symbols per word, each repeated N times and paced by a
//   programmable rate divider.
//   Ports:
//     clk, rst           block clock, synchronous active-high reset
//     cfg_enable         allow new words to be accepted
//     cfg_msb_first      symbol order within a word (latched per word)
//     cfg_rate_div       min cycles between output beats, 0 treated as 1
//     s_axis (slave)     32-bit input word stream
//     m_axis (master)    2-bit symbol stream
//     sts_busy           a word is in progress
//     sts_underflow_cnt  saturating count of mid-packet starvation gaps
//   Optional build macro: QPSK_SYM_SCHED_PREFETCH_EN adds a one-entry prefetch
//   register so consecutive words stream without the IDLE bubble.
module qpsk_sym_sched
    import qpsk_sym_sched_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned UFL_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_enable,
    input  logic                cfg_msb_first,
    input  logic [DIV_W-1:0]    cfg_rate_div,
    qpsk_sym_sched_if.slave     s_axis,
    qpsk_sym_sched_if.master    m_axis,
    output logic                sts_busy,
    output logic [UFL_W-1:0]    sts_underflow_cnt
);

    localparam int unsigned REP_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_q;
    logic [WORD_W-1:0]  word_q;
    logic               last_q;
    logic               msb_q;
    logic [DIV_W-1:0]   div_q;
    logic [3:0]         sym_q;
    logic [REP_W-1:0]   rep_q;
    logic               in_pkt_q;
    logic               starve_q;
    logic [UFL_W-1:0]   ufl_q;

`ifdef QPSK_SYM_SCHED_PREFETCH_EN
    logic [WORD_W-1:0]  pf_data_q;
    logic               pf_last_q;
    logic               pf_valid_q;
`endif

    logic               pace_zero;
    logic [DIV_W-1:0]   pace_ld;
    logic               m_valid;
    logic               m_hs;
    logic               beat_last;
    logic               word_done;
    logic               s_ready;
    logic               s_hs;
    logic               start_word;
    logic [WORD_W-1:0]  ld_data;
    logic               ld_last;
    logic               starving;

    always_comb begin
        pace_ld   = (div_q == '0) ? '0 : (div_q - DIV_W'(1));
        m_valid   = (state_q == EMIT) && pace_zero;
        m_hs      = m_valid && m_axis.tready;
        beat_last = (sym_q == 4'(SYM_PER_WORD - 1)) && (rep_q == REP_W'(N - 1));
        word_done = m_hs && beat_last;
        ld_data   = s_axis.tdata;
        ld_last   = s_axis.tlast;
`ifdef QPSK_SYM_SCHED_PREFETCH_EN
        s_ready    = !rst && cfg_enable && ((state_q == IDLE) || !pf_valid_q);
        s_hs       = s_ready && s_axis.tvalid;
        // The next word comes from prefetch if held, else straight from the input
        // when it arrives on the final beat; IDLE is only entered when neither.
        start_word = ((state_q == IDLE) && s_hs) ||
                     (word_done && (pf_valid_q || s_hs));
        if (pf_valid_q) begin
            ld_data = pf_data_q;
            ld_last = pf_last_q;
        end
        starving   = in_pkt_q && cfg_enable && !s_axis.tvalid &&
                     ((state_q == IDLE) || (word_done && !pf_valid_q));
`else
        s_ready    = !rst && cfg_enable && (state_q == IDLE);
        s_hs       = s_ready && s_axis.tvalid;
        start_word = (state_q == IDLE) && s_hs;
        starving   = in_pkt_q && cfg_enable && !s_axis.tvalid && (state_q == IDLE);
`endif
    end

    qpsk_sym_pacer #(
        .DIV_W (DIV_W)
    ) u_pacer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (start_word && (state_q == IDLE)),
        .load_i     (m_hs),
        .hold_i     (m_valid && !m_axis.tready),
        .load_val_i (pace_ld),
        .zero_o     (pace_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            word_q   <= '0;
            last_q   <= 1'b0;
            msb_q    <= 1'b0;
            div_q    <= '0;
            sym_q    <= '0;
            rep_q    <= '0;
            in_pkt_q <= 1'b0;
            starve_q <= 1'b0;
            ufl_q    <= '0;
`ifdef QPSK_SYM_SCHED_PREFETCH_EN
            pf_data_q  <= '0;
            pf_last_q  <= 1'b0;
            pf_valid_q <= 1'b0;
`endif
        end else begin
            if (s_hs) begin
                in_pkt_q <= !s_axis.tlast;
            end

            // One count per starvation gap; the flag re-arms on the next accept.
            if (s_hs) begin
                starve_q <= 1'b0;
            end else if (starving && !starve_q) begin
                starve_q <= 1'b1;
                if (ufl_q != '1) begin
                    ufl_q <= ufl_q + UFL_W'(1);
                end
            end

            if (start_word) begin
                state_q <= EMIT;
                word_q  <= ld_data;
                last_q  <= ld_last;
                msb_q   <= cfg_msb_first;
                div_q   <= cfg_rate_div;
                sym_q   <= '0;
                rep_q   <= '0;
            end else if (m_hs) begin
                if (beat_last) begin
                    state_q <= IDLE;
                end else if (rep_q == REP_W'(N - 1)) begin
                    rep_q <= '0;
                    sym_q <= sym_q + 4'd1;
                end else begin
                    rep_q <= rep_q + REP_W'(1);
                end
            end

`ifdef QPSK_SYM_SCHED_PREFETCH_EN
            if (start_word && pf_valid_q) begin
                pf_valid_q <= 1'b0;
            end else if (s_hs && !start_word) begin
                pf_data_q  <= s_axis.tdata;
                pf_last_q  <= s_axis.tlast;
                pf_valid_q <= 1'b1;
            end
`endif
        end
    end

    assign s_axis.tready     = s_ready;
    assign m_axis.tvalid     = m_valid;
    assign m_axis.tdata      = sym_sel(word_q, sym_q, msb_q);
    assign m_axis.tlast      = m_valid && last_q && beat_last;
    assign sts_busy          = (state_q != IDLE);
    assign sts_underflow_cnt = ufl_q;

endmodule
